// File: rtl/mini_src_pkg.sv
// Shared encodings for the Mini-SRC control sequencer: opcodes, IR field positions
// and the control-step state type.
package mini_src_pkg;

  localparam logic [4:0] OP_ADD      = 5'b00011;
  localparam logic [4:0] OP_SUB      = 5'b00100;
  localparam logic [4:0] OP_AND      = 5'b00101;
  localparam logic [4:0] OP_OR       = 5'b00110;
  localparam logic [4:0] OP_SHIFT_LO = 5'b00111;
  localparam logic [4:0] OP_SHIFT_HI = 5'b01011;
  localparam logic [4:0] OP_DIV      = 5'b01111;
  localparam logic [4:0] OP_MUL      = 5'b10000;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_e;

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational IR decode: register fields to one-hot selects plus legality.
// MULDIV_EN makes DIV/MUL legal opcodes.
module ir_decode
  import mini_src_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5
) (
  input  logic [31:0]          ir_i,
  output logic [OPCODE_W-1:0]  opcode_o,
  output logic [NUM_REGS-1:0]  ra_oh_o,
  output logic [NUM_REGS-1:0]  rb_oh_o,
  output logic [NUM_REGS-1:0]  rc_oh_o,
  output logic                 legal_o,
  output logic                 is_muldiv_o
);

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       op_ok, fld_ok;
  logic       unused_ir;

  assign op = ir_i[OPC_LSB +: 5];
  assign ra = ir_i[RA_LSB +: 4];
  assign rb = ir_i[RB_LSB +: 4];
  assign rc = ir_i[RC_LSB +: 4];
  assign unused_ir = ^ir_i[RC_LSB-1:0];

  function automatic logic [NUM_REGS-1:0] to_oh(input logic [3:0] f);
    to_oh = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(f) == i) to_oh[i] = 1'b1;
  endfunction

  assign ra_oh_o  = to_oh(ra);
  assign rb_oh_o  = to_oh(rb);
  assign rc_oh_o  = to_oh(rc);
  assign opcode_o = OPCODE_W'(op);

  assign is_muldiv_o = op_is_muldiv(op);
  assign fld_ok = (int'(ra) < NUM_REGS) && (int'(rb) < NUM_REGS) && (int'(rc) < NUM_REGS);

`ifdef MULDIV_EN
  assign op_ok = ((op >= OP_ADD) && (op <= OP_SHIFT_HI)) || is_muldiv_o;
`else
  assign op_ok = (op >= OP_ADD) && (op <= OP_SHIFT_HI);
`endif

  assign legal_o = op_ok && fld_ok;

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired fetch/execute control-step sequencer for register-register ALU ops.
// Define MULDIV_EN to build the DIV/MUL path (T6, LOin/HIin/Zhighout).
module alu_op_sequencer
  import mini_src_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int OPCODE_W     = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                clock_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [31:0]         ir_in_i,
  input  logic                mem_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic                mem_err_o,
  output logic                PCout_o,
  output logic                MARin_o,
  output logic                IncPC_o,
  output logic                PCin_o,
  output logic                Read_o,
  output logic                MDRin_o,
  output logic                MDRout_o,
  output logic                IRin_o,
  output logic                Yin_o,
  output logic                Zin_o,
  output logic                Zlowout_o,
  output logic                Zhighout_o,
  output logic                LOin_o,
  output logic                HIin_o,
  output logic [NUM_REGS-1:0] reg_out_sel_o,
  output logic [NUM_REGS-1:0] reg_in_sel_o,
  output logic [OPCODE_W-1:0] alu_op_o
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, illegal_q, illegal_d, mem_err_q, mem_err_d;

  logic [OPCODE_W-1:0] opcode;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic                legal, is_muldiv;

  ir_decode #(.NUM_REGS(NUM_REGS), .OPCODE_W(OPCODE_W)) u_dec (
    .ir_i        (ir_in_i),
    .opcode_o    (opcode),
    .ra_oh_o     (ra_oh),
    .rb_oh_o     (rb_oh),
    .rc_oh_o     (rc_oh),
    .legal_o     (legal),
    .is_muldiv_o (is_muldiv)
  );

`ifndef MULDIV_EN
  logic unused_muldiv;
  assign unused_muldiv = is_muldiv;
`endif

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    mem_err_d     = 1'b0;
    PCout_o       = 1'b0;
    MARin_o       = 1'b0;
    IncPC_o       = 1'b0;
    PCin_o        = 1'b0;
    Read_o        = 1'b0;
    MDRin_o       = 1'b0;
    MDRout_o      = 1'b0;
    IRin_o        = 1'b0;
    Yin_o         = 1'b0;
    Zin_o         = 1'b0;
    Zlowout_o     = 1'b0;
    Zhighout_o    = 1'b0;
    LOin_o        = 1'b0;
    HIin_o        = 1'b0;
    reg_out_sel_o = '0;
    reg_in_sel_o  = '0;
    alu_op_o      = '0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_T0;
      S_T0: begin
        PCout_o = 1'b1; MARin_o = 1'b1; IncPC_o = 1'b1; Zin_o = 1'b1;
        cnt_d   = '0;
        state_d = S_T1;
      end
      S_T1: begin
        // Re-loading PC each wait cycle is harmless: Z keeps PC+1 until T4.
        Zlowout_o = 1'b1; PCin_o = 1'b1; Read_o = 1'b1; MDRin_o = 1'b1;
        if (mem_ready_i) begin
          state_d = S_T2;
        end else if (cnt_q == CNT_W'(MEM_WAIT_MAX)) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_T2: begin
        MDRout_o = 1'b1; IRin_o = 1'b1;
        state_d  = S_T3;
      end
      S_T3: begin
        if (!legal) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else begin
          reg_out_sel_o = rb_oh; Yin_o = 1'b1;
          state_d       = S_T4;
        end
      end
      S_T4: begin
        reg_out_sel_o = rc_oh; alu_op_o = opcode; Zin_o = 1'b1;
        state_d       = S_T5;
      end
      S_T5: begin
        Zlowout_o = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) begin
          LOin_o  = 1'b1;
          state_d = S_T6;
        end else
`endif
        begin
          reg_in_sel_o = ra_oh;
          state_d      = S_IDLE;
          done_d       = 1'b1;
        end
      end
`ifdef MULDIV_EN
      S_T6: begin
        Zhighout_o = 1'b1; HIin_o = 1'b1;
        state_d    = S_IDLE;
        done_d     = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign illegal_o = illegal_q;
  assign mem_err_o = mem_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle output trace after start, then
// hand-computed checks. Cycle n is the interval after the n-th edge following start.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir_in;
  logic        busy, done, illegal, mem_err;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [15:0] rout, rin;
  logic [4:0]  alu_op;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clock_i(clk), .clear_i(clear), .start_i(start), .ir_in_i(ir_in), .mem_ready_i(mem_ready),
    .busy_o(busy), .done_o(done), .illegal_o(illegal), .mem_err_o(mem_err),
    .PCout_o(PCout), .MARin_o(MARin), .IncPC_o(IncPC), .PCin_o(PCin), .Read_o(Read),
    .MDRin_o(MDRin), .MDRout_o(MDRout), .IRin_o(IRin), .Yin_o(Yin), .Zin_o(Zin),
    .Zlowout_o(Zlowout), .Zhighout_o(Zhighout), .LOin_o(LOin), .HIin_o(HIin),
    .reg_out_sel_o(rout), .reg_in_sel_o(rin), .alu_op_o(alu_op)
  );

  logic [31:0] busy_t, done_t, ill_t, merr_t, read_t, mdrin_t, pcin_t, irin_t;
  logic [31:0] yin_t, zin_t, loin_t, hiin_t, zhi_t, any_t;
  logic [15:0] rout_t [32];
  logic [15:0] rin_t  [32];
  logic [4:0]  alu_t  [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_done();
    for (int c = 1; c < 32; c++) if (done_t[c]) return c;
    return 0;
  endfunction

  function automatic logic [15:0] rin_or();
    logic [15:0] r = '0;
    for (int c = 1; c < 32; c++) r |= rin_t[c];
    return r;
  endfunction

  // wait_n < 0 keeps mem_ready low for the whole run; start_c/clear_c pulse those inputs in that cycle
  task automatic run(input logic [31:0] ir, input int wait_n, input int ncyc,
                     input int start_c, input int clear_c);
    {busy_t, done_t, ill_t, merr_t, read_t, mdrin_t, pcin_t, irin_t} = '0;
    {yin_t, zin_t, loin_t, hiin_t, zhi_t, any_t} = '0;
    for (int c = 0; c < 32; c++) begin
      rout_t[c] = '0; rin_t[c] = '0; alu_t[c] = '0;
    end
    ir_in = ir; start = 1'b1; mem_ready = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      busy_t[c] = busy;  done_t[c] = done;   ill_t[c] = illegal; merr_t[c] = mem_err;
      read_t[c] = Read;  mdrin_t[c] = MDRin; pcin_t[c] = PCin;   irin_t[c] = IRin;
      yin_t[c]  = Yin;   zin_t[c] = Zin;     loin_t[c] = LOin;   hiin_t[c] = HIin;
      zhi_t[c]  = Zhighout;
      rout_t[c] = rout;  rin_t[c] = rin;     alu_t[c] = alu_op;
      any_t[c]  = |{busy, done, illegal, mem_err, PCout, MARin, IncPC, PCin, Read, MDRin,
                    MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, rout, rin, alu_op};
      start     = (c == start_c);
      clear     = (c == clear_c);
      mem_ready = !((wait_n < 0) ? 1'b1 : (c >= 2 && c < 2 + wait_n));
    end
    start = 1'b0; clear = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_outs", |{done, illegal, mem_err, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
                        IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, rout, rin, alu_op}, 0);
    clear = 1'b0;
    @(posedge clk); #1;

    // AND r1, r2, r3
    run(32'h2891_8000, 0, 10, 0, 0);
    chk("t1_busy_c1",  busy_t[1], 1);
    chk("t1_done_cyc", first_done(), 7);
    chk("t1_no_ill",   ill_t[7], 0);
    chk("t1_done_one", done_t[8], 0);
    chk("t1_idle_c7",  busy_t[7], 0);
    chk("t1_rout_t3",  rout_t[4], 16'h0004);
    chk("t1_rout_t4",  rout_t[5], 16'h0008);
    chk("t1_alu_t4",   alu_t[5], 5'b00101);
    chk("t1_alu_t3",   alu_t[4], 0);
    chk("t1_rin_t5",   rin_t[6], 16'h0002);
    chk("t1_reads",    $countones(read_t), 1);

    // same with three memory wait cycles
    run(32'h2891_8000, 3, 12, 0, 0);
    chk("t2_reads",    $countones(read_t), 4);
    chk("t2_mdrin",    $countones(mdrin_t), 4);
    chk("t2_pcin",     $countones(pcin_t), 4);
    chk("t2_done_cyc", first_done(), 10);
    chk("t2_rin_t5",   rin_t[9], 16'h0002);

    // memory never answers: abort once the counter has reached its limit
    run(32'h2891_8000, -1, 22, 0, 0);
    chk("t3_done_cyc", first_done(), 18);
    chk("t3_mem_err",  merr_t[18], 1);
    chk("t3_no_ill",   ill_t[18], 0);
    chk("t3_irin",     $countones(irin_t), 0);
    chk("t3_idle",     busy_t[18], 0);

    // MUL r1, r2, r3
    run(32'h8091_8000, 0, 10, 0, 0);
`ifdef MULDIV_EN
    chk("t4_done_cyc", first_done(), 8);
    chk("t4_loin_t5",  loin_t[6], 1);
    chk("t4_hiin_t6",  hiin_t[7], 1);
    chk("t4_zhi_t6",   zhi_t[7], 1);
    chk("t4_no_ill",   ill_t[8], 0);
`else
    chk("t4_done_cyc", first_done(), 5);
    chk("t4_illegal",  ill_t[5], 1);
    chk("t4_no_loin",  $countones(loin_t), 0);
`endif
    chk("t4_rin_zero", rin_or(), 0);

    // unsupported opcode 11111
    run(32'hF891_8000, 0, 8, 0, 0);
    chk("t5_done_cyc", first_done(), 5);
    chk("t5_illegal",  ill_t[5], 1);
    chk("t5_rin_zero", rin_or(), 0);
    chk("t5_zin_once", $countones(zin_t), 1);
    chk("t5_no_yin",   $countones(yin_t), 0);

    // ADD with a stray start in T2 and clear during T4
    run(32'h1891_8000, 0, 10, 3, 5);
    chk("t6_t3_yin",   yin_t[4], 1);
    chk("t6_t4_zin",   zin_t[5], 1);
    chk("t6_idle",     busy_t[6], 0);
    chk("t6_outs0",    any_t[6], 0);
    chk("t6_no_done",  first_done(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
